// File: rtl/ibex_simple_system_pkg.sv
// Shared types and constants for the simple-system bus watchdog slice.
package ibex_simple_system_pkg;

    // Bus field widths of the Ibex data bus
    localparam int unsigned BusAddrW = 32;
    localparam int unsigned BusDataW = 32;
    localparam int unsigned BusBeW   = 4;

    // Read data returned with a forced timeout error
    localparam logic [BusDataW-1:0] BusWdErrRdata = 32'h0;

    // Watchdog FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } bus_wd_state_e;

endpackage

// File: rtl/ibex_simple_system_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module ibex_simple_system_sat_cnt #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    localparam logic [Width-1:0] CntOne = Width'(1);
    localparam logic [Width-1:0] CntMax = '1;

    logic [Width-1:0] cnt_q;
    logic [Width-1:0] cnt_d;

    // Next value: clear wins, otherwise increment unless already saturated
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CntOne;
        end
    end

    // Count register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ibex_simple_system_bus_watchdog.sv
// Single-outstanding bus stage that forwards requests to a peripheral and
// substitutes an error response when the peripheral stays silent too long.
module ibex_simple_system_bus_watchdog
    import ibex_simple_system_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 16,
    parameter int unsigned DrainCycles   = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                host_req_i,
    output logic                host_gnt_o,
    input  logic                host_we_i,
    input  logic [BusBeW-1:0]   host_be_i,
    input  logic [BusAddrW-1:0] host_addr_i,
    input  logic [BusDataW-1:0] host_wdata_i,
    output logic                host_rvalid_o,
    output logic [BusDataW-1:0] host_rdata_o,
    output logic                host_err_o,

    output logic                dev_req_o,
    output logic                dev_we_o,
    output logic [BusBeW-1:0]   dev_be_o,
    output logic [BusAddrW-1:0] dev_addr_o,
    output logic [BusDataW-1:0] dev_wdata_o,
    input  logic                dev_rvalid_i,
    input  logic [BusDataW-1:0] dev_rdata_i,
    input  logic                dev_err_i,

    output logic                busy_o,
    output logic [15:0]         timeout_cnt_o
);

    localparam logic [15:0] TimeoutLast = 16'(TimeoutCycles - 1);
    localparam logic [15:0] DrainLast   = 16'(DrainCycles - 1);
    localparam logic [15:0] CycOne      = 16'd1;

    bus_wd_state_e state_q, state_d;
    logic [15:0]   cyc_q, cyc_d;
    logic          gnt;
    logic          accept;
    logic          timeout_inc;

    // Request fields pass straight through; only the handshake is gated
    assign dev_we_o    = host_we_i;
    assign dev_be_o    = host_be_i;
    assign dev_addr_o  = host_addr_i;
    assign dev_wdata_o = host_wdata_i;

    // Grant when idle, or when the outstanding response completes this cycle
    assign gnt        = (state_q == IDLE) || ((state_q == WAIT) && dev_rvalid_i);
    assign accept     = host_req_i && gnt;
    assign host_gnt_o = gnt;
    assign dev_req_o  = accept;
    assign busy_o     = (state_q != IDLE);

    // Next-state, cycle counter and host response decode
    always_comb begin
        state_d       = state_q;
        cyc_d         = cyc_q;
        host_rvalid_o = 1'b0;
        host_rdata_o  = '0;
        host_err_o    = 1'b0;
        timeout_inc   = 1'b0;

        case (state_q)
            IDLE: begin
                // Stray device responses here are dropped
                if (accept) begin
                    state_d = WAIT;
                    cyc_d   = '0;
                end
            end

            WAIT: begin
                if (dev_rvalid_i) begin
                    host_rvalid_o = 1'b1;
                    host_rdata_o  = dev_rdata_i;
                    host_err_o    = dev_err_i;
                    if (accept) begin
                        state_d = WAIT;
                        cyc_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cyc_q == TimeoutLast) begin
                    // Peripheral never answered: synthesise an error response
                    host_rvalid_o = 1'b1;
                    host_rdata_o  = BusWdErrRdata;
                    host_err_o    = 1'b1;
                    timeout_inc   = 1'b1;
                    state_d       = DRAIN;
                    cyc_d         = '0;
                end else begin
                    cyc_d = cyc_q + CycOne;
                end
            end

            DRAIN: begin
                // Absorb a late response so it cannot be mistaken for a new one
                if (dev_rvalid_i) begin
                    state_d = IDLE;
                end else if (cyc_q == DrainLast) begin
                    state_d = IDLE;
                end else begin
                    cyc_d = cyc_q + CycOne;
                end
            end

            default: begin
                state_d = IDLE;
                cyc_d   = '0;
            end
        endcase
    end

    // State and cycle counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
        end
    end

    ibex_simple_system_sat_cnt #(
        .Width (16)
    ) u_timeout_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (1'b0),
        .inc_i (timeout_inc),
        .cnt_o (timeout_cnt_o)
    );

endmodule

// File: tb/tb_ibex_simple_system_bus_watchdog.sv
// Directed self-checking bench for the bus watchdog (TimeoutCycles=16, DrainCycles=16).
module tb_ibex_simple_system_bus_watchdog;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        host_req_i;
    logic        host_gnt_o;
    logic        host_we_i;
    logic [3:0]  host_be_i;
    logic [31:0] host_addr_i;
    logic [31:0] host_wdata_i;
    logic        host_rvalid_o;
    logic [31:0] host_rdata_o;
    logic        host_err_o;
    logic        dev_req_o;
    logic        dev_we_o;
    logic [3:0]  dev_be_o;
    logic [31:0] dev_addr_o;
    logic [31:0] dev_wdata_o;
    logic        dev_rvalid_i;
    logic [31:0] dev_rdata_i;
    logic        dev_err_i;
    logic        busy_o;
    logic [15:0] timeout_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    ibex_simple_system_bus_watchdog #(
        .TimeoutCycles (16),
        .DrainCycles   (16)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .host_req_i    (host_req_i),
        .host_gnt_o    (host_gnt_o),
        .host_we_i     (host_we_i),
        .host_be_i     (host_be_i),
        .host_addr_i   (host_addr_i),
        .host_wdata_i  (host_wdata_i),
        .host_rvalid_o (host_rvalid_o),
        .host_rdata_o  (host_rdata_o),
        .host_err_o    (host_err_o),
        .dev_req_o     (dev_req_o),
        .dev_we_o      (dev_we_o),
        .dev_be_o      (dev_be_o),
        .dev_addr_o    (dev_addr_o),
        .dev_wdata_o   (dev_wdata_o),
        .dev_rvalid_i  (dev_rvalid_i),
        .dev_rdata_i   (dev_rdata_i),
        .dev_err_i     (dev_err_i),
        .busy_o        (busy_o),
        .timeout_cnt_o (timeout_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Let combinational outputs settle before sampling
    task automatic settle();
        #1;
    endtask

    task automatic dev_idle();
        dev_rvalid_i = 1'b0;
        dev_rdata_i  = 32'h0;
        dev_err_i    = 1'b0;
    endtask

    task automatic read_req(input logic [31:0] addr);
        host_req_i   = 1'b1;
        host_we_i    = 1'b0;
        host_be_i    = 4'hF;
        host_addr_i  = addr;
        host_wdata_i = 32'h0;
    endtask

    initial begin
        rst_i        = 1'b1;
        host_req_i   = 1'b0;
        host_we_i    = 1'b0;
        host_be_i    = 4'h0;
        host_addr_i  = 32'h0;
        host_wdata_i = 32'h0;
        dev_idle();
        tick();
        tick();
        rst_i = 1'b0;
        settle();

        // Reset state
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_tcnt", {16'b0, timeout_cnt_o}, 32'd0);
        check("rst_rvalid", {31'b0, host_rvalid_o}, 32'd0);
        check("rst_gnt", {31'b0, host_gnt_o}, 32'd1);
        $display("reset: busy=%0b tcnt=%0d", busy_o, timeout_cnt_o);

        // Prompt device: write 0x3 to 0x0, response after one cycle
        tick();
        host_req_i   = 1'b1;
        host_we_i    = 1'b1;
        host_be_i    = 4'hF;
        host_addr_i  = 32'h0;
        host_wdata_i = 32'h3;
        settle();
        check("wr_gnt", {31'b0, host_gnt_o}, 32'd1);
        check("wr_dev_req", {31'b0, dev_req_o}, 32'd1);
        check("wr_dev_we", {31'b0, dev_we_o}, 32'd1);
        check("wr_dev_wdata", dev_wdata_o, 32'h3);
        check("wr_dev_be", {28'b0, dev_be_o}, 32'hF);
        tick();
        host_req_i   = 1'b0;
        dev_rvalid_i = 1'b1;
        settle();
        check("wr_rvalid", {31'b0, host_rvalid_o}, 32'd1);
        check("wr_err", {31'b0, host_err_o}, 32'd0);
        check("wr_busy_k1", {31'b0, busy_o}, 32'd1);
        tick();
        dev_idle();
        settle();
        check("wr_busy_after", {31'b0, busy_o}, 32'd0);
        check("wr_rvalid_after", {31'b0, host_rvalid_o}, 32'd0);
        check("wr_tcnt", {16'b0, timeout_cnt_o}, 32'd0);
        $display("prompt write: done");

        // Back-to-back reads: four accepts, responses on consecutive cycles
        read_req(32'h10);
        settle();
        check("b2b_gnt0", {31'b0, host_gnt_o}, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i < 4) read_req(32'h10 + 32'(4 * i));
            else host_req_i = 1'b0;
            dev_rvalid_i = 1'b1;
            dev_rdata_i  = 32'hA5A50000 + 32'(i);
            settle();
            check($sformatf("b2b_rvalid%0d", i), {31'b0, host_rvalid_o}, 32'd1);
            check($sformatf("b2b_rdata%0d", i), host_rdata_o, 32'hA5A50000 + 32'(i));
            check($sformatf("b2b_gnt%0d", i), {31'b0, host_gnt_o}, 32'd1);
            check($sformatf("b2b_devreq%0d", i), {31'b0, dev_req_o}, (i < 4) ? 32'd1 : 32'd0);
            $display("b2b response %0d rdata=%h", i, host_rdata_o);
        end
        tick();
        dev_idle();
        settle();
        check("b2b_busy_after", {31'b0, busy_o}, 32'd0);

        // Silent device: forced error at cycle 16, then 16 drain cycles
        read_req(32'h20);
        tick();
        host_req_i = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            settle();
            check($sformatf("sil_rvalid_k%0d", k), {31'b0, host_rvalid_o}, 32'd0);
            check($sformatf("sil_gnt_k%0d", k), {31'b0, host_gnt_o}, 32'd0);
            tick();
        end
        settle();
        check("sil_rvalid_k16", {31'b0, host_rvalid_o}, 32'd1);
        check("sil_err_k16", {31'b0, host_err_o}, 32'd1);
        check("sil_rdata_k16", host_rdata_o, 32'h0);
        check("sil_gnt_k16", {31'b0, host_gnt_o}, 32'd0);
        tick();
        for (int k = 17; k <= 32; k++) begin
            settle();
            check($sformatf("drain_gnt_k%0d", k), {31'b0, host_gnt_o}, 32'd0);
            check($sformatf("drain_rvalid_k%0d", k), {31'b0, host_rvalid_o}, 32'd0);
            check($sformatf("drain_busy_k%0d", k), {31'b0, busy_o}, 32'd1);
            tick();
        end
        settle();
        check("sil_busy_k33", {31'b0, busy_o}, 32'd0);
        check("sil_tcnt", {16'b0, timeout_cnt_o}, 32'd1);
        $display("silent device: tcnt=%0d", timeout_cnt_o);

        // Late response at cycle 20 is swallowed in DRAIN
        read_req(32'h24);
        tick();
        host_req_i = 1'b0;
        for (int k = 1; k <= 15; k++) tick();
        settle();
        check("late_err_k16", {31'b0, host_err_o}, 32'd1);
        check("late_rvalid_k16", {31'b0, host_rvalid_o}, 32'd1);
        tick();
        tick();
        tick();
        tick();
        dev_rvalid_i = 1'b1;
        dev_rdata_i  = 32'h12345678;
        settle();
        check("late_rvalid_k20", {31'b0, host_rvalid_o}, 32'd0);
        check("late_busy_k20", {31'b0, busy_o}, 32'd1);
        tick();
        dev_idle();
        settle();
        check("late_busy_k21", {31'b0, busy_o}, 32'd0);
        check("late_tcnt", {16'b0, timeout_cnt_o}, 32'd2);
        $display("late response: tcnt=%0d", timeout_cnt_o);

        // Device error at k=3 is forwarded unchanged
        read_req(32'h28);
        tick();
        host_req_i = 1'b0;
        tick();
        tick();
        dev_rvalid_i = 1'b1;
        dev_err_i    = 1'b1;
        dev_rdata_i  = 32'hDEADBEEF;
        settle();
        check("derr_rvalid", {31'b0, host_rvalid_o}, 32'd1);
        check("derr_err", {31'b0, host_err_o}, 32'd1);
        check("derr_rdata", host_rdata_o, 32'hDEADBEEF);
        tick();
        dev_idle();
        settle();
        check("derr_tcnt", {16'b0, timeout_cnt_o}, 32'd2);
        $display("device error: rdata forwarded");

        // Response exactly at k=TimeoutCycles wins over the timeout
        read_req(32'h2C);
        tick();
        host_req_i = 1'b0;
        for (int k = 1; k <= 15; k++) tick();
        dev_rvalid_i = 1'b1;
        dev_rdata_i  = 32'hCAFE0016;
        settle();
        check("edge_rvalid_k16", {31'b0, host_rvalid_o}, 32'd1);
        check("edge_err_k16", {31'b0, host_err_o}, 32'd0);
        check("edge_rdata_k16", host_rdata_o, 32'hCAFE0016);
        tick();
        dev_idle();
        settle();
        check("edge_busy_after", {31'b0, busy_o}, 32'd0);
        check("edge_tcnt", {16'b0, timeout_cnt_o}, 32'd2);
        $display("edge response at k=16: done");

        // Reset mid-WAIT at k=5, device answers at k=7
        read_req(32'h30);
        tick();
        host_req_i = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        rst_i = 1'b1;
        settle();
        check("rstw_rvalid_k5", {31'b0, host_rvalid_o}, 32'd0);
        tick();
        rst_i = 1'b0;
        settle();
        check("rstw_busy_k6", {31'b0, busy_o}, 32'd0);
        check("rstw_tcnt_k6", {16'b0, timeout_cnt_o}, 32'd0);
        check("rstw_rvalid_k6", {31'b0, host_rvalid_o}, 32'd0);
        tick();
        dev_rvalid_i = 1'b1;
        dev_rdata_i  = 32'h0BADF00D;
        settle();
        check("rstw_rvalid_k7", {31'b0, host_rvalid_o}, 32'd0);
        check("rstw_gnt_k7", {31'b0, host_gnt_o}, 32'd1);
        tick();
        dev_idle();
        settle();
        check("rstw_busy_k8", {31'b0, busy_o}, 32'd0);
        $display("reset mid-wait: busy=%0b tcnt=%0d", busy_o, timeout_cnt_o);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
